// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite transfer encodings
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
endpackage

// File: rtl/ahblite_cmd_master.sv
// rtl/ahblite_cmd_master.sv - command-stream to AHB-Lite single-transfer initiator
module ahblite_cmd_master
  import ahb_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL   = 4'b0011,
  parameter bit         ERR_REISSUE = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  logic        r_ap_valid;
  logic [31:0] r_ap_addr;
  logic        r_ap_write;
  logic [2:0]  r_ap_size;
  logic [31:0] r_ap_wdata;
  logic        r_dp_valid;
  logic        r_dp_write;
  logic [31:0] r_hwdata;
  logic        r_err_hold;
  logic        r_cancel;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic w_accept;
  logic w_advance;
  logic w_err_done;
  logic w_complete;

  assign cmd_ready  = !r_ap_valid || (HREADY && !r_err_hold);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_advance  = HREADY && !r_err_hold;
  assign w_err_done = HREADY && r_err_hold;
  assign w_complete = r_dp_valid && HREADY;

  // err_hold masks the pending address phase so the slave never samples it
  assign HTRANS    = (r_ap_valid && !r_err_hold) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = r_ap_addr;
  assign HWRITE    = r_ap_write;
  assign HSIZE     = r_ap_size;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = r_hwdata;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_ap_valid || r_dp_valid || r_rsp_valid || r_cancel;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ap_valid <= 1'b0;
      r_ap_addr  <= '0;
      r_ap_write <= 1'b0;
      r_ap_size  <= '0;
      r_ap_wdata <= '0;
    end else if (w_accept) begin
      r_ap_valid <= 1'b1;
      r_ap_addr  <= cmd_addr;
      r_ap_write <= cmd_write;
      r_ap_size  <= cmd_size;
      r_ap_wdata <= cmd_wdata;
    end else if (w_advance || (w_err_done && !ERR_REISSUE)) begin
      r_ap_valid <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_hwdata   <= '0;
    end else if (w_advance) begin
      r_dp_valid <= r_ap_valid;
      r_dp_write <= r_ap_write;
      if (r_ap_valid && r_ap_write) begin
        r_hwdata <= r_ap_wdata;
      end
    end else if (w_err_done) begin
      r_dp_valid <= 1'b0;
    end
  end

  // First ERROR cycle arrives with HREADY low; the second (HREADY high) releases the hold
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_err_hold <= 1'b0;
      r_cancel   <= 1'b0;
    end else begin
      if (r_dp_valid && HRESP && !HREADY) begin
        r_err_hold <= 1'b1;
      end else if (HREADY) begin
        r_err_hold <= 1'b0;
      end
      r_cancel <= w_err_done && r_ap_valid && !ERR_REISSUE;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_complete || r_cancel;
      if (w_complete) begin
        r_rsp_err   <= HRESP;
        r_rsp_rdata <= (!r_dp_write && !HRESP) ? HRDATA : '0;
      end else if (r_cancel) begin
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= '0;
      end
    end
  end
endmodule
